// File: rtl/ctrl_seq.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared memory port,
// datapath strobes, and sticky trap reporting (illegal opcode, SYSTEM, bus timeout).
module ctrl_seq #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       rd_w,
  input  logic       is_branch,
  input  logic       is_jmp,
  input  logic       br_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we,
  output logic [1:0] rf_src,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [1:0] r_cause;
  logic [1:0] w_cause_next;
  logic       r_gap;
  logic       w_is_store;

  assign w_is_store = (opcode == OP_STORE);

  // r_gap holds off a fetch for one cycle after any completed request (store ack -> FETCH).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= 8'd0;
      r_cause <= 2'd0;
      r_gap   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      r_gap   <= mem_req & mem_ack;
      r_cnt   <= (mem_req && !mem_ack) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    rf_src       = 2'd0;
    retire       = 1'b0;
    trap         = 1'b0;
    trap_cause   = 2'd0;

    case (r_state)
      S_FETCH: begin
        if (!r_gap) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we  = 1'b1;
            w_next = S_DECODE;
          end else if (r_cnt == TIMEOUT) begin
            w_next       = S_TRAP;
            w_cause_next = 2'd3;
          end
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR,
          OP_BRANCH, OP_LOAD, OP_STORE, OP_MISC: w_next = S_EXEC;
          OP_SYSTEM: begin
            w_next       = S_TRAP;
            w_cause_next = 2'd2;
          end
          default: begin
            w_next       = S_TRAP;
            w_cause_next = 2'd1;
          end
        endcase
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || w_is_store) begin
          w_next = S_MEM;
        end else if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken;
          retire = 1'b1;
          w_next = S_FETCH;
        end else if (is_jmp) begin
          rf_we  = 1'b1;
          rf_src = 2'd2;
          pc_we  = 1'b1;
          pc_sel = 1'b1;
          retire = 1'b1;
          w_next = S_FETCH;
        end else begin
          rf_we  = rd_w;
          pc_we  = 1'b1;
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_is_store;
        if (mem_ack) begin
          if (w_is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            mdr_we = 1'b1;
            w_next = S_WB;
          end
        end else if (r_cnt == TIMEOUT) begin
          w_next       = S_TRAP;
          w_cause_next = 2'd3;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        rf_src = 2'd1;
        pc_we  = 1'b1;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = r_cause;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset abandons any request in flight: nothing is driven while rst is high.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      rf_we        = 1'b0;
      rf_src       = 2'd0;
      retire       = 1'b0;
      trap         = 1'b0;
      trap_cause   = 2'd0;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: an instruction-level model expands each instruction into
// its expected per-cycle strobe trace, which is compared against the observed outputs.
module tb_ctrl_seq;
  localparam int T = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Observed bundle: {req, we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, rf_we, rf_src, retire, trap, cause}
  localparam logic [13:0] REQ     = 14'h2000;
  localparam logic [13:0] WE      = 14'h1000;
  localparam logic [13:0] AS      = 14'h0800;
  localparam logic [13:0] IR      = 14'h0400;
  localparam logic [13:0] MDR     = 14'h0200;
  localparam logic [13:0] PCWE    = 14'h0100;
  localparam logic [13:0] PCSEL   = 14'h0080;
  localparam logic [13:0] RFWE    = 14'h0040;
  localparam logic [13:0] SRC_MDR = 14'h0010;
  localparam logic [13:0] SRC_PC4 = 14'h0020;
  localparam logic [13:0] RET     = 14'h0008;
  localparam logic [13:0] TRAPB   = 14'h0004;

  localparam int C_ILL = 0, C_SYS = 1, C_ALU = 2, C_BR = 3, C_JMP = 4, C_LD = 5, C_ST = 6;

  logic clk = 1'b0;
  logic rst, rd_w, is_branch, is_jmp, br_taken, mem_ack;
  logic [6:0] opcode;
  logic mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_sel, rf_we, retire, trap;
  logic [1:0] rf_src, trap_cause;
  logic [13:0] obs;

  ctrl_seq #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rd_w(rd_w), .is_branch(is_branch),
    .is_jmp(is_jmp), .br_taken(br_taken), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .mdr_we(mdr_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .rf_src(rf_src), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_sel, rf_we,
                rf_src, retire, trap, trap_cause};

  logic [13:0] expQ[$];
  logic [13:0] obsQ[$];
  bit          ackQ[$];
  bit          rstQ[$];
  int checks = 0;
  int errors = 0;
  bit gap = 0;

  function automatic int cls(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_MISC: return C_ALU;
      OP_JAL, OP_JALR: return C_JMP;
      OP_BRANCH: return C_BR;
      OP_LOAD:   return C_LD;
      OP_STORE:  return C_ST;
      OP_SYSTEM: return C_SYS;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic void push(input logic [13:0] e, input bit a, input bit r = 1'b0);
    expQ.push_back(e);
    ackQ.push_back(a);
    rstQ.push_back(r);
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void trap_cycles(input logic [1:0] c);
    repeat (20) push(TRAPB | 14'(c), rnd());
  endfunction

  // Expected trace of one instruction. Acks in cycles without a request are random
  // because the sequencer must ignore them; a store's ack is followed by one idle cycle.
  function automatic void plan_instr(input logic [6:0] op, input bit rdw, input bit br,
                                     input int wf, input int wm);
    logic [13:0] m;
    int c = cls(op);
    if (gap) push(14'h0, rnd());
    gap = 0;
    if (wf > T) begin
      repeat (T + 1) push(REQ, 1'b0);
      trap_cycles(2'd3);
      return;
    end
    repeat (wf) push(REQ, 1'b0);
    push(REQ | IR, 1'b1);
    push(14'h0, rnd());
    case (c)
      C_ILL: trap_cycles(2'd1);
      C_SYS: trap_cycles(2'd2);
      C_ALU: push(PCWE | RET | (rdw ? RFWE : 14'h0), rnd());
      C_BR:  push(PCWE | RET | (br ? PCSEL : 14'h0), rnd());
      C_JMP: push(RFWE | SRC_PC4 | PCWE | PCSEL | RET, rnd());
      default: begin
        push(14'h0, rnd());
        m = REQ | AS | ((c == C_ST) ? WE : 14'h0);
        if (wm > T) begin
          repeat (T + 1) push(m, 1'b0);
          trap_cycles(2'd3);
        end else begin
          repeat (wm) push(m, 1'b0);
          if (c == C_ST) begin
            push(m | PCWE | RET, 1'b1);
            gap = 1;
          end else begin
            push(m | MDR, 1'b1);
            push(RFWE | SRC_MDR | PCWE | RET, rnd());
          end
        end
      end
    endcase
  endfunction

  task automatic run_instr(input logic [6:0] op, input bit rdw, input bit br,
                           input int wf, input int wm);
    int s = expQ.size();
    plan_instr(op, rdw, br, wf, wm);
    opcode    = op;
    rd_w      = rdw;
    is_branch = (cls(op) == C_BR);
    is_jmp    = (cls(op) == C_JMP);
    br_taken  = br;
    for (int i = s; i < expQ.size(); i++) begin
      rst     = rstQ[i];
      mem_ack = ackQ[i];
      #3;
      obsQ.push_back(obs);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic clear_q();
    expQ.delete(); obsQ.delete(); ackQ.delete(); rstQ.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    gap = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1; mem_ack = rnd(); opcode = 7'($urandom);
      is_branch = rnd(); is_jmp = rnd(); br_taken = rnd(); rd_w = rnd();
      #3;
      checks++;
      if (obs !== 14'h0) begin
        errors++; $display("FAIL reset_hold cyc %0d got %h exp %h", i, obs, 14'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      checks++;
      if (obs !== REQ) begin
        errors++; $display("FAIL reset_fetch cyc %0d got %h exp %h", i, obs, REQ);
      end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_alu();
    logic [6:0] ops [5] = '{OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_MISC};
    clear_q();
    run_instr(OP_OP, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 8; k++)
      run_instr(ops[$urandom_range(0, 4)], rnd(), rnd(), $urandom_range(0, T), 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL alu cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_load_store();
    clear_q();
    run_instr(OP_LOAD, 1'b1, 1'b0, 0, 3);
    run_instr(OP_STORE, 1'b0, 1'b0, 0, 0);
    run_instr(OP_STORE, 1'b0, 1'b0, 1, 2);
    run_instr(OP_LOAD, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++)
      run_instr(rnd() ? OP_LOAD : OP_STORE, rnd(), rnd(), $urandom_range(0, 3),
                $urandom_range(0, T));
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL ldst cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    clear_q();
    run_instr(OP_BRANCH, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BRANCH, 1'b0, 1'b0, 0, 0);
    run_instr(OP_JAL, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++)
      run_instr(rnd() ? OP_BRANCH : OP_JALR, rnd(), rnd(), $urandom_range(0, 2), 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL brjmp cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_traps();
    logic [6:0] op;
    clear_q();
    run_instr(7'h7F, 1'b0, 1'b0, 0, 0);
    do_reset();
    run_instr(OP_SYSTEM, 1'b0, 1'b0, 1, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      do op = 7'($urandom); while (cls(op) != C_ILL);
      run_instr(op, rnd(), rnd(), 0, 0);
      do_reset();
    end
    run_instr(OP_OP, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL trap cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_q();
    run_instr(OP_OP, 1'b1, 1'b0, T + 1, 0);
    do_reset();
    run_instr(OP_OP, 1'b1, 1'b0, T, 0);
    run_instr(OP_LOAD, 1'b1, 1'b0, 0, T);
    run_instr(OP_STORE, 1'b0, 1'b0, 0, T + 1);
    do_reset();
    run_instr(OP_LOAD, 1'b1, 1'b0, 0, T + 1);
    do_reset();
    run_instr(OP_BRANCH, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL timeout cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    clear_q();
    opcode = OP_LOAD; rd_w = 1'b1; is_branch = 1'b0; is_jmp = 1'b0; br_taken = 1'b0;
    push(REQ | IR, 1'b1);
    push(14'h0, 1'b0);
    push(14'h0, 1'b0);
    push(REQ | AS, 1'b0);
    push(REQ | AS, 1'b0);
    push(14'h0, 1'b0, 1'b1);
    for (int i = 0; i < expQ.size(); i++) begin
      rst = rstQ[i]; mem_ack = ackQ[i];
      #3;
      obsQ.push_back(obs);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    gap = 0;
    run_instr(OP_OP, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL rst_mem cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [10] = '{OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR,
                             OP_BRANCH, OP_LOAD, OP_STORE, OP_MISC};
    clear_q();
    for (int k = 0; k < 30; k++)
      run_instr(ops[$urandom_range(0, 9)], rnd(), rnd(), $urandom_range(0, T),
                $urandom_range(0, T));
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("FAIL b2b cyc %0d got %h exp %h", i, obsQ[i], expQ[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; opcode = 7'h0;
    rd_w = 1'b0; is_branch = 1'b0; is_jmp = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_traps();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
